// File: rtl/kat_adc_autoconfig.sv
// Power-up register loader: replays a {reg addr, reg data} table into an ADC
// serialiser over a start/done handshake, with per-phase timeout and abort.
module kat_adc_autoconfig #(
   parameter int unsigned NUM_ENTRIES    = 8,
   parameter int unsigned POWERUP_CYCLES = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned AUTOSTART      = 0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        tbl_we,
   input  logic [3:0]  tbl_waddr,
   input  logic [19:0] tbl_wdata,
   input  logic [4:0]  num_entries,
   input  logic        trigger,
   input  logic        abort,
   output logic [3:0]  config_addr,
   output logic [15:0] config_data,
   output logic        config_start,
   input  logic        config_done,
   output logic        busy,
   output logic        seq_done,
   output logic        seq_error,
   output logic [3:0]  entry_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PWAIT,
      S_ISSUE,
      S_ACCEPT,
      S_COMPLETE,
      S_ERROR
   } state_t;

   localparam int unsigned MAXC = (POWERUP_CYCLES > TIMEOUT_CYCLES) ? POWERUP_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] PW_LAST = CW'(POWERUP_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]    NUM_MAX = 5'(NUM_ENTRIES);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [4:0]    r_idx;
   logic [4:0]    r_num;
   logic [19:0]   r_tbl [16];
   logic [3:0]    r_addr;
   logic [15:0]   r_data;
   logic          r_start;
   logic          r_done;
   logic          r_err;
   logic          r_auto_pend;

   logic          w_busy;
   logic          w_start_req;
   logic          w_timeout;
   logic          w_wr_ok;
   logic [4:0]    w_idx_next;
   logic [4:0]    w_num_clamped;
   logic [19:0]   w_entry;

   assign w_busy        = (r_state != S_IDLE);
   assign w_start_req   = (trigger || r_auto_pend) && !abort;
   assign w_timeout     = (r_cnt == TO_LAST);
   assign w_wr_ok       = tbl_we && !w_busy && (32'(tbl_waddr) < NUM_ENTRIES);
   assign w_idx_next    = r_idx + 5'd1;
   assign w_num_clamped = (num_entries > NUM_MAX) ? NUM_MAX : num_entries;
   assign w_entry       = r_tbl[r_idx[3:0]];

   assign config_addr  = r_addr;
   assign config_data  = r_data;
   assign config_start = r_start;
   assign busy         = w_busy;
   assign seq_done     = r_done;
   assign seq_error    = r_err;
   assign entry_idx    = r_idx[3:0];

   // Entries at or above NUM_ENTRIES are never written and stay at their reset value.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int unsigned i = 0; i < 16; i++) begin
            r_tbl[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_tbl[tbl_waddr] <= tbl_wdata;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_num       <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_start     <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_auto_pend <= (AUTOSTART != 0);
      end else begin
         r_start <= 1'b0;
         // Abort preempts every active phase; ERROR itself only waits for the serialiser.
         if (abort && (r_state != S_IDLE) && (r_state != S_ERROR)) begin
            r_state <= S_ERROR;
            r_err   <= 1'b1;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_start_req) begin
                     r_state     <= S_PWAIT;
                     r_done      <= 1'b0;
                     r_err       <= 1'b0;
                     r_idx       <= '0;
                     r_cnt       <= '0;
                     r_num       <= w_num_clamped;
                     r_auto_pend <= 1'b0;
                  end
               end
               S_PWAIT: begin
                  if (r_cnt == PW_LAST) begin
                     r_cnt <= '0;
                     if (r_num == 5'd0) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= S_ISSUE;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_ISSUE: begin
                  if (config_done) begin
                     r_addr  <= w_entry[19:16];
                     r_data  <= w_entry[15:0];
                     r_start <= 1'b1;
                     r_state <= S_ACCEPT;
                     r_cnt   <= '0;
                  end else if (w_timeout) begin
                     r_state <= S_ERROR;
                     r_err   <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_ACCEPT: begin
                  if (!config_done) begin
                     r_state <= S_COMPLETE;
                     r_cnt   <= '0;
                  end else if (w_timeout) begin
                     r_state <= S_ERROR;
                     r_err   <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_COMPLETE: begin
                  if (config_done) begin
                     r_idx <= w_idx_next;
                     r_cnt <= '0;
                     if (w_idx_next == r_num) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= S_ISSUE;
                     end
                  end else if (w_timeout) begin
                     r_state <= S_ERROR;
                     r_err   <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_ERROR: begin
                  if (config_done) begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_kat_adc_autoconfig.sv
// Directed bench for kat_adc_autoconfig: table replay, timeout, abort, busy
// lockout, entry clamping and asynchronous reset with AUTOSTART.
module tb_kat_adc_autoconfig;

   localparam int PWR = 20;
   localparam int TMO = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst_a = 1'b1;
   logic        tbl_we = 1'b0;
   logic [3:0]  tbl_waddr = '0;
   logic [19:0] tbl_wdata = '0;
   logic [4:0]  num_entries = '0;
   logic        trigger = 1'b0;
   logic        abort = 1'b0;
   logic        ovr_en = 1'b0;
   logic        ovr_val = 1'b1;

   logic [3:0]  cfg_addr, cfg_addr_a;
   logic [15:0] cfg_data, cfg_data_a;
   logic        cfg_start, cfg_start_a;
   logic        cfg_done, cfg_done_a;
   logic        busy, busy_a;
   logic        seq_done, seq_done_a;
   logic        seq_error, seq_error_a;
   logic [3:0]  entry_idx, entry_idx_a;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   kat_adc_autoconfig #(
      .NUM_ENTRIES(8), .POWERUP_CYCLES(PWR), .TIMEOUT_CYCLES(TMO), .AUTOSTART(0)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
      .tbl_wdata(tbl_wdata), .num_entries(num_entries), .trigger(trigger), .abort(abort),
      .config_addr(cfg_addr), .config_data(cfg_data), .config_start(cfg_start),
      .config_done(cfg_done), .busy(busy), .seq_done(seq_done), .seq_error(seq_error),
      .entry_idx(entry_idx)
   );

   kat_adc_autoconfig #(
      .NUM_ENTRIES(8), .POWERUP_CYCLES(PWR), .TIMEOUT_CYCLES(TMO), .AUTOSTART(1)
   ) dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst_a), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
      .tbl_wdata(tbl_wdata), .num_entries(num_entries), .trigger(trigger), .abort(abort),
      .config_addr(cfg_addr_a), .config_data(cfg_data_a), .config_start(cfg_start_a),
      .config_done(cfg_done_a), .busy(busy_a), .seq_done(seq_done_a), .seq_error(seq_error_a),
      .entry_idx(entry_idx_a)
   );

   // Serialiser models: done drops the cycle after start, rises 40 cycles later.
   logic ser_done = 1'b1;
   int   ser_cnt = 0;
   always @(posedge clk) begin
      if (cfg_start === 1'b1) begin
         ser_done <= 1'b0;
         ser_cnt  <= 40;
      end else if (ser_cnt != 0) begin
         ser_cnt <= ser_cnt - 1;
         if (ser_cnt == 1) ser_done <= 1'b1;
      end
   end
   assign cfg_done = ovr_en ? ovr_val : ser_done;

   logic ser_done_a = 1'b1;
   int   ser_cnt_a = 0;
   always @(posedge clk) begin
      if (cfg_start_a === 1'b1) begin
         ser_done_a <= 1'b0;
         ser_cnt_a  <= 40;
      end else if (ser_cnt_a != 0) begin
         ser_cnt_a <= ser_cnt_a - 1;
         if (ser_cnt_a == 1) ser_done_a <= 1'b1;
      end
   end
   assign cfg_done_a = ser_done_a;

   logic [19:0] log_mem [64];
   int          n_start = 0;
   int          n_start_a = 0;
   always @(posedge clk) begin
      if (cfg_start === 1'b1 && n_start < 64) begin
         log_mem[n_start] <= {cfg_addr, cfg_data};
         n_start <= n_start + 1;
      end
      if (cfg_start_a === 1'b1) n_start_a <= n_start_a + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return cfg_start;
         1:       return seq_done;
         2:       return seq_error;
         3:       return cfg_start_a;
         default: return seq_done_a;
      endcase
   endfunction

   task automatic wait_for(input int sel, output int cyc);
      cyc = 0;
      while (sig(sel) !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      int nb;

      tick(2);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(seq_done), 0);
      check("rst_err", 32'(seq_error), 0);
      check("rst_start", 32'(cfg_start), 0);
      check("rst_addr_data", 32'({cfg_addr, cfg_data}), 0);
      check("rst_idx", 32'(entry_idx), 0);
      rst = 1'b0;
      tick(1);

      tbl_we = 1'b1; tbl_waddr = 4'd0; tbl_wdata = 20'h11234; tick(1);
      tbl_waddr = 4'd1; tbl_wdata = 20'h2ABCD; tick(1);
      tbl_waddr = 4'd2; tbl_wdata = 20'hF0001; tick(1);
      tbl_waddr = 4'd9; tbl_wdata = 20'hDEAD0; tick(1);
      tbl_we = 1'b0;

      num_entries = 5'd3; nb = n_start;
      trigger = 1'b1; tick(1); trigger = 1'b0;
      check("trig_busy", 32'(busy), 1);
      wait_for(0, cyc);
      check("first_start_lat", cyc, PWR + 1);
      check("first_entry", 32'({cfg_addr, cfg_data}), 32'h11234);
      wait_for(1, cyc);
      check("seq3_done", 32'(seq_done), 1);
      check("seq3_busy", 32'(busy), 0);
      check("seq3_err", 32'(seq_error), 0);
      check("seq3_idx", 32'(entry_idx), 3);
      check("seq3_count", n_start - nb, 3);
      check("seq3_e0", 32'(log_mem[nb]), 32'h11234);
      check("seq3_e1", 32'(log_mem[nb + 1]), 32'h2ABCD);
      check("seq3_e2", 32'(log_mem[nb + 2]), 32'hF0001);

      num_entries = 5'd0; nb = n_start;
      trigger = 1'b1; tick(1); trigger = 1'b0;
      check("zero_done_cleared", 32'(seq_done), 0);
      wait_for(1, cyc);
      check("zero_done_lat", cyc + 1, PWR + 1);
      check("zero_no_start", n_start - nb, 0);
      check("zero_busy", 32'(busy), 0);

      num_entries = 5'd1; ovr_en = 1'b1; ovr_val = 1'b1; nb = n_start;
      trigger = 1'b1; tick(1); trigger = 1'b0;
      wait_for(0, cyc);
      wait_for(2, cyc);
      check("timeout_lat", cyc, TMO);
      check("timeout_one_start", n_start - nb, 1);
      check("timeout_no_done", 32'(seq_done), 0);
      tick(1);
      check("timeout_idle", 32'(busy), 0);
      check("timeout_err_sticky", 32'(seq_error), 1);
      ovr_en = 1'b0;

      num_entries = 5'd3; nb = n_start;
      trigger = 1'b1; tick(1); trigger = 1'b0;
      check("abrun_err_cleared", 32'(seq_error), 0);
      wait_for(0, cyc);
      tick(1);
      wait_for(0, cyc);
      check("abrun_idx1", 32'(entry_idx), 1);
      check("abrun_e1", 32'({cfg_addr, cfg_data}), 32'h2ABCD);
      tick(3);
      abort = 1'b1; ovr_en = 1'b1; ovr_val = 1'b0;
      tick(1);
      abort = 1'b0;
      check("abort_err", 32'(seq_error), 1);
      check("abort_busy", 32'(busy), 1);
      check("abort_no_done", 32'(seq_done), 0);
      tick(10);
      check("abort_hold_busy", 32'(busy), 1);
      check("abort_starts", n_start - nb, 2);
      ovr_val = 1'b1;
      tick(1);
      check("abort_idle", 32'(busy), 0);
      check("abort_err_sticky", 32'(seq_error), 1);
      tick(50);
      ovr_en = 1'b0;

      nb = n_start;
      trigger = 1'b1; tick(1); trigger = 1'b0;
      check("retrig_idx0", 32'(entry_idx), 0);
      check("retrig_err_cleared", 32'(seq_error), 0);
      tbl_we = 1'b1; tbl_waddr = 4'd0; tbl_wdata = 20'h55555; tick(1);
      tbl_we = 1'b0;
      wait_for(0, cyc);
      check("retrig_e0", 32'({cfg_addr, cfg_data}), 32'h11234);
      tick(1);
      trigger = 1'b1; tick(1); trigger = 1'b0;
      wait_for(1, cyc);
      check("busy_lock_count", n_start - nb, 3);
      check("busy_lock_e0", 32'(log_mem[nb]), 32'h11234);
      check("busy_lock_e2", 32'(log_mem[nb + 2]), 32'hF0001);
      check("busy_lock_err", 32'(seq_error), 0);

      num_entries = 5'd31; nb = n_start;
      trigger = 1'b1; tick(1); trigger = 1'b0;
      wait_for(1, cyc);
      check("clamp_count", n_start - nb, 8);
      check("clamp_idx", 32'(entry_idx), 8);
      check("clamp_e0", 32'(log_mem[nb]), 32'h11234);
      check("clamp_e7", 32'(log_mem[nb + 7]), 0);

      num_entries = 5'd0;
      rst_a = 1'b0;
      tick(1);
      check("auto_busy", 32'(busy_a), 1);
      wait_for(4, cyc);
      check("auto_done", 32'(seq_done_a), 1);
      tbl_we = 1'b1; tbl_waddr = 4'd0; tbl_wdata = 20'h7CAFE; tick(1);
      tbl_we = 1'b0;
      num_entries = 5'd2;
      trigger = 1'b1; tick(1); trigger = 1'b0;
      wait_for(3, cyc);
      check("auto_e0", 32'({cfg_addr_a, cfg_data_a}), 32'h7CAFE);
      tick(1);
      rst_a = 1'b1;
      #1;
      check("async_busy", 32'(busy_a), 0);
      check("async_addr_data", 32'({cfg_addr_a, cfg_data_a}), 0);
      tick(2);
      nb = n_start_a;
      rst_a = 1'b0;
      tick(1);
      check("rerun_busy", 32'(busy_a), 1);
      check("rerun_idx", 32'(entry_idx_a), 0);
      wait_for(3, cyc);
      check("rerun_start_idx", 32'(entry_idx_a), 0);
      check("rerun_tbl_cleared", 32'({cfg_addr_a, cfg_data_a}), 0);
      tick(1);
      wait_for(4, cyc);
      check("rerun_done", 32'(seq_done_a), 1);
      check("rerun_count", n_start_a - nb, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
